// File: rtl/dma_mem_pkg.sv
// Shared types and helpers for the DMA memory-side responder.
package dma_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } xfer_state_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dma_fifo.sv
// Show-ahead FIFO: head entry is presented on rd_data whenever empty is low.
module dma_fifo
    import dma_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned PW        = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [PW:0]           count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    // Full/empty are judged on the pre-pop occupancy, so there is no bypass path.
    always_comb begin
        do_push  = push && (count_q != (PW+1)'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign count   = count_q;

endmodule

// File: rtl/dma_mem_responder.sv
// Memory end of the DMA read/write contract: credit-limited line reads into a
// show-ahead buffer, and buffered AFU writes drained to a valid/ready port.
module dma_mem_responder
    import dma_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned RD_FIFO_DEPTH = 16,
    parameter int unsigned WR_FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_go,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ADDR_WIDTH:0]   rd_size,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  rd_done,
    input  logic                  wr_go,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH:0]   wr_size,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  wr_done,
    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                  mem_rd_ready,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_wr_ready
);

    localparam int unsigned SW  = ADDR_WIDTH + 1;
    localparam int unsigned RCW = ptr_width(RD_FIFO_DEPTH) + 1;
    localparam int unsigned WCW = ptr_width(WR_FIFO_DEPTH) + 1;

    xfer_state_e           rd_state_q, rd_state_d, wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0] rd_base_q, rd_base_d, wr_base_q, wr_base_d;
    logic [SW-1:0]         rd_size_q, rd_size_d, wr_size_q, wr_size_d;
    logic [SW-1:0]         req_cnt_q, req_cnt_d, pop_cnt_q, pop_cnt_d;
    logic [SW-1:0]         push_cnt_q, push_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [RCW-1:0]        outst_q, outst_d;
    logic                  rd_done_q, rd_done_d, wr_done_q, wr_done_d;

    logic [RCW-1:0]        rd_fifo_count;
    logic [WCW-1:0]        wr_fifo_count;
    logic                  rd_fifo_full, wr_fifo_full, wr_fifo_empty;
    logic                  rd_credit, rd_issue, rd_pop, wr_push, wr_drain;
    logic                  unused_fifo_status;

    // A request is only issued if the buffer can absorb every response in flight.
    assign rd_credit   = (outst_q + rd_fifo_count) < RCW'(RD_FIFO_DEPTH);
    assign mem_rd_req  = (rd_state_q == ST_ACTIVE) && (req_cnt_q < rd_size_q) && rd_credit;
    assign mem_rd_addr = rd_base_q + req_cnt_q[ADDR_WIDTH-1:0];
    assign rd_issue    = mem_rd_req && mem_rd_ready;
    assign rd_pop      = rd_en && !empty;
    assign rd_done     = rd_done_q;

    assign full        = (wr_state_q != ST_ACTIVE) || wr_fifo_full || (push_cnt_q == wr_size_q);
    assign wr_push     = wr_en && !full;
    assign mem_wr_req  = !wr_fifo_empty;
    assign mem_wr_addr = wr_base_q + wr_cnt_q[ADDR_WIDTH-1:0];
    assign wr_drain    = mem_wr_req && mem_wr_ready;
    assign wr_done     = wr_done_q;

    assign unused_fifo_status = ^{rd_fifo_full, wr_fifo_count};

    always_comb begin
        rd_state_d = rd_state_q;
        rd_base_d  = rd_base_q;
        rd_size_d  = rd_size_q;
        req_cnt_d  = req_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        outst_d    = outst_q;
        case ({rd_issue, mem_rd_valid})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
        if (rd_issue) req_cnt_d = req_cnt_q + 1'b1;
        if (rd_pop) begin
            pop_cnt_d = pop_cnt_q + 1'b1;
            if ((rd_state_q == ST_ACTIVE) && (pop_cnt_d == rd_size_q)) rd_state_d = ST_DONE;
        end
        if (rd_go && (rd_state_q != ST_ACTIVE)) begin
            rd_base_d  = rd_addr;
            rd_size_d  = rd_size;
            req_cnt_d  = '0;
            pop_cnt_d  = '0;
            rd_state_d = (rd_size == '0) ? ST_DONE : ST_ACTIVE;
        end
        rd_done_d = (rd_state_d == ST_DONE);
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_base_d  = wr_base_q;
        wr_size_d  = wr_size_q;
        push_cnt_d = push_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        if (wr_push) push_cnt_d = push_cnt_q + 1'b1;
        if (wr_drain) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if ((wr_state_q == ST_ACTIVE) && (wr_cnt_d == wr_size_q)) wr_state_d = ST_DONE;
        end
        if (wr_go && (wr_state_q != ST_ACTIVE)) begin
            wr_base_d  = wr_addr;
            wr_size_d  = wr_size;
            push_cnt_d = '0;
            wr_cnt_d   = '0;
            wr_state_d = (wr_size == '0) ? ST_DONE : ST_ACTIVE;
        end
        wr_done_d = (wr_state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= ST_IDLE;
            rd_base_q  <= '0;
            rd_size_q  <= '0;
            req_cnt_q  <= '0;
            pop_cnt_q  <= '0;
            outst_q    <= '0;
            rd_done_q  <= 1'b0;
            wr_state_q <= ST_IDLE;
            wr_base_q  <= '0;
            wr_size_q  <= '0;
            push_cnt_q <= '0;
            wr_cnt_q   <= '0;
            wr_done_q  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_base_q  <= rd_base_d;
            rd_size_q  <= rd_size_d;
            req_cnt_q  <= req_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            outst_q    <= outst_d;
            rd_done_q  <= rd_done_d;
            wr_state_q <= wr_state_d;
            wr_base_q  <= wr_base_d;
            wr_size_q  <= wr_size_d;
            push_cnt_q <= push_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_done_q  <= wr_done_d;
        end
    end

    dma_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(RD_FIFO_DEPTH)) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mem_rd_valid),
        .push_data (mem_rd_data),
        .pop       (rd_pop),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (rd_fifo_full),
        .count     (rd_fifo_count)
    );

    dma_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(WR_FIFO_DEPTH)) u_wr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_push),
        .push_data (wr_data),
        .pop       (wr_drain),
        .rd_data   (mem_wr_data),
        .empty     (wr_fifo_empty),
        .full      (wr_fifo_full),
        .count     (wr_fifo_count)
    );

endmodule
